// File: rtl/rom_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_sequencer_if
// Description : Host/ROM side bus of the ROM sequencer. The master modport is
//               the host plus the ROM, the slave modport is the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int PER_W  = 24
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] seq_len;
    logic [PER_W-1:0]  period;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] step_data;
    logic              step_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, loop_en, seq_len, period, rom_data,
        input  rom_addr, step_data, step_valid, busy, done
    );

    modport slave (
        input  start, stop, loop_en, seq_len, period, rom_data,
        output rom_addr, step_data, step_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/rom_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rom_sequencer
// Description : Steps through a falling-edge-registered lookup ROM at a
//               programmable rate, presenting each byte as a held word with a
//               one-cycle strobe. One-shot or looped playback with abort.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_sequencer #(
    parameter int ROM_DEPTH = 32,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int PER_W     = 24
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    rom_sequencer_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_ROM_DEPTH = ADDR_W'(ROM_DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [PER_W-1:0]  c_PER_ONE   = PER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_index, w_index_nxt;   // doubles as the ROM address
    logic [PER_W-1:0]  r_cnt,   w_cnt_nxt;
    logic [ADDR_W-1:0] r_len,   w_len_nxt;
    logic [PER_W-1:0]  r_per,   w_per_nxt;
    logic [DATA_W-1:0] r_data,  w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_done,  w_done_nxt;

    logic [ADDR_W-1:0] w_len_clamp;
    logic [PER_W-1:0]  w_per_clamp;
    logic              w_last;

    // Length is limited to the populated ROM; a zero period still gives one
    // hold cycle so the step counter can never underflow.
    assign w_len_clamp = (bus.seq_len > c_ROM_DEPTH) ? c_ROM_DEPTH : bus.seq_len;
    assign w_per_clamp = (bus.period == '0) ? c_PER_ONE : bus.period;
    assign w_last      = (r_index == (r_len - c_ADDR_ONE));

    // Next-state and next-register values; strobes default low each cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_per_nxt   = r_per;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Abort dominates start; an empty sequence never launches.
                if (bus.start && !bus.stop && (bus.seq_len != '0)) begin
                    w_state_nxt = S_FETCH;
                    w_index_nxt = '0;
                    w_len_nxt   = w_len_clamp;
                    w_per_nxt   = w_per_clamp;
                end
            end
            S_FETCH: begin
                // ROM has registered the addressed byte on the falling edge.
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_data_nxt  = bus.rom_data;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = r_per - c_PER_ONE;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_PER_ONE;
                end else if (!w_last) begin
                    w_index_nxt = r_index + c_ADDR_ONE;
                    w_state_nxt = S_FETCH;
                end else if (bus.loop_en) begin
                    // loop_en is looked at only here so clearing it mid-pass
                    // lets the current pass run to its end.
                    w_index_nxt = '0;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_per   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_per   <= w_per_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.rom_addr   = r_index;
    assign bus.step_data  = r_data;
    assign bus.step_valid = r_valid;
    assign bus.done       = r_done;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
